// File: rtl/apb_slv_mem_responder.sv
// ---------------------------------------------------------------------------
// apb_slv_mem_responder
// APB3 completer backed by a word-addressed register memory. The wait-state
// count is programmable per transfer. Bad addresses return pslverr. Byte
// strobes are optional.
//
// Optional feature macro: APB_SLV_PSTRB_EN
//   defined   : pstrb port present. Good writes update only the strobed bytes.
//               A read with any strobe set returns pslverr=1 and prdata=0.
//   undefined : no pstrb port. Good writes update the full word.
//
// Ports
//   clk      in   APB clock, rising edge
//   resetn   in   async active-low reset, clears FSM, outputs and memory
//   psel     in   select
//   penable  in   access-phase enable
//   pwrite   in   1=write, 0=read
//   paddr    in   byte address [ADDR_W]
//   pwdata   in   write data [DATA_W]
//   pstrb    in   byte strobes [DATA_W/8] (APB_SLV_PSTRB_EN only)
//   cfg_wait in   wait states per transfer [WAIT_W], sampled at setup
//   prdata   out  read data, registered, 0 unless pready
//   pready   out  transfer complete, registered
//   pslverr  out  error response, registered, 0 unless pready
// ---------------------------------------------------------------------------
module apb_slv_mem_responder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       WAIT_W    = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    input  logic [WAIT_W-1:0]   cfg_wait,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned ADDR_B = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned IDX_W  = $clog2(DEPTH);

    // Window bounds are compared one bit wider so the end address cannot wrap.
    localparam logic [ADDR_W:0]   BASE_EXT   = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]   END_EXT    = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(DEPTH * BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Request captured at the setup edge. Later changes on the bus are ignored.
    typedef struct packed {
        logic              write;
        logic              err;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] wdata;
        logic [BYTES-1:0]  strb;
    } req_t;

    state_t              state;
    req_t                req;
    logic [WAIT_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                setup;
    logic [ADDR_W:0]     paddr_ext;
    logic [ADDR_W-1:0]   offset;
    logic                addr_bad;
    logic                setup_err;
    logic [IDX_W-1:0]    setup_idx;
    logic [BYTES-1:0]    strb_in;

    // Decode of the live bus, used only on a setup edge.
    always_comb begin
        setup     = psel & ~penable;
        paddr_ext = {1'b0, paddr};
        offset    = paddr - BASE_ADDR;
        addr_bad  = (paddr_ext < BASE_EXT) || (paddr_ext >= END_EXT) ||
                    ((paddr & ALIGN_MASK) != '0);
        setup_idx = IDX_W'(offset >> ADDR_B);
`ifdef APB_SLV_PSTRB_EN
        strb_in   = pstrb;
        setup_err = addr_bad | (~pwrite & (|pstrb));
`else
        strb_in   = '1;
        setup_err = addr_bad;
`endif
    end

    // Transfer FSM and memory. A setup seen in any state (re)starts a transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            req     <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (setup) begin
            req.write <= pwrite;
            req.err   <= setup_err;
            req.idx   <= setup_idx;
            req.wdata <= pwdata;
            req.strb  <= strb_in;
            cnt       <= cfg_wait;
            if (cfg_wait == '0) begin
                state   <= S_RESP;
                pready  <= 1'b1;
                pslverr <= setup_err;
                prdata  <= (!pwrite && !setup_err) ? mem[setup_idx] : '0;
            end else begin
                state   <= S_WAIT;
                pready  <= 1'b0;
                pslverr <= 1'b0;
                prdata  <= '0;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (!psel) begin
                        state   <= S_IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end else if (cnt == WAIT_W'(1)) begin
                        state   <= S_RESP;
                        pready  <= 1'b1;
                        pslverr <= req.err;
                        prdata  <= (!req.write && !req.err) ? mem[req.idx] : '0;
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                S_RESP: begin
                    // psel & penable here, with pready already high: completion edge.
                    if (psel && req.write && !req.err) begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (req.strb[b]) begin
                                mem[req.idx][8*b +: 8] <= req.wdata[8*b +: 8];
                            end
                        end
                    end
                    state   <= S_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                end
                default: begin
                    // IDLE: an access phase without a setup is ignored.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slv_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_apb_slv_mem_responder
// A directed APB driver pushes one expected response per transfer: read data,
// error flag and the cycle in which pready must rise. A negedge monitor pops
// an entry each time pready is high and compares it. The monitor also checks
// that prdata and pslverr are 0 whenever pready is low.
// ---------------------------------------------------------------------------
module tb_apb_slv_mem_responder;

    localparam logic [31:0] B = 32'h0000_1000;

    logic        clk;
    logic        resetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb;
`endif
    logic [3:0]  cfg_wait;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_slv_mem_responder #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (256),
        .BASE_ADDR (B),
        .WAIT_W    (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb    (pstrb),
`endif
        .cfg_wait (cfg_wait),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] cyc   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (resetn === 1'b1) begin
            tests++;
            if (pready === 1'b1) begin
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pready cyc=%0d prdata=%h pslverr=%b (no transfer expected)",
                             cyc, prdata, pslverr);
                end else begin
                    e = q.pop_front();
                    if (prdata !== e.rdata || pslverr !== e.err || cyc !== e.cyc) begin
                        fails++;
                        $display("FAIL response got prdata=%h pslverr=%b cyc=%0d, want prdata=%h pslverr=%b cyc=%0d",
                                 prdata, pslverr, cyc, e.rdata, e.err, e.cyc);
                    end
                end
            end else if (prdata !== 32'h0 || pslverr !== 1'b0) begin
                fails++;
                $display("FAIL idle_outputs cyc=%0d pready=%b prdata=%h pslverr=%b, want 0 while pready low",
                         cyc, pready, prdata, pslverr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One APB transfer starting #1 after a posedge. A non-negative abort_after
    // drops psel after that many wait edges and expects no response.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [3:0] w,
                        input logic [31:0] exp_rd, input logic exp_err, input int abort_after);
        bit done;
        int n;
        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = wdata;
        cfg_wait = w;
`ifdef APB_SLV_PSTRB_EN
        pstrb    = strb;
`else
        if (strb == 4'h0) pwdata = wdata;
`endif
        @(posedge clk); #1;
        if (abort_after < 0) q.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + 32'(w)});
        penable  = 1'b1;
        paddr    = ~addr;
        pwdata   = ~wdata;
        cfg_wait = ~w;
        if (abort_after >= 0) begin
            repeat (abort_after) @(posedge clk);
            #1;
        end else begin
            done = 1'b0;
            n    = 0;
            while (!done && n < 64) begin
                @(negedge clk);
                done = (pready === 1'b1);
                n++;
            end
            tests++;
            if (!done) begin
                fails++;
                $display("FAIL timeout addr=%h got no pready want pready within 64 cycles", addr);
            end
            @(posedge clk); #1;
        end
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        resetn   = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        cfg_wait = '0;
`ifdef APB_SLV_PSTRB_EN
        pstrb    = '0;
`endif
        #3;
        check("reset_pready",  32'(pready),  32'h0);
        check("reset_pslverr", 32'(pslverr), 32'h0);
        check("reset_prdata",  prdata,       32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Zero-wait write then read-back.
        xfer(1'b1, B + 32'd4, 32'hDEAD_BEEF, 4'hF, 4'd0, 32'h0,         1'b0, -1);
        xfer(1'b0, B + 32'd4, 32'h0,         4'h0, 4'd0, 32'hDEAD_BEEF, 1'b0, -1);
        // Three wait states on a never-written word.
        xfer(1'b0, B + 32'd8, 32'h0,         4'h0, 4'd3, 32'h0,         1'b0, -1);
        // Last word of the window.
        xfer(1'b1, B + 32'd1020, 32'hA5A5_0F0F, 4'hF, 4'd1, 32'h0,      1'b0, -1);
        xfer(1'b0, B + 32'd1020, 32'h0,      4'h0, 4'd2, 32'hA5A5_0F0F, 1'b0, -1);

        // Bad addresses: past the end, misaligned write, below base, past-end write.
        xfer(1'b0, B + 32'd1024, 32'h0,         4'h0, 4'd0, 32'h0, 1'b1, -1);
        xfer(1'b1, B + 32'd2,    32'h1234_5678, 4'hF, 4'd0, 32'h0, 1'b1, -1);
        xfer(1'b0, B - 32'd4,    32'h0,         4'h0, 4'd1, 32'h0, 1'b1, -1);
        xfer(1'b1, B + 32'd1024, 32'hCAFE_F00D, 4'hF, 4'd2, 32'h0, 1'b1, -1);
        xfer(1'b0, B,            32'h0,         4'h0, 4'd0, 32'h0, 1'b0, -1);

        // Access phase with no setup: must produce no response.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = B + 32'd4; cfg_wait = 4'd0;
        repeat (4) @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;

        // Reset two edges into a 5-wait read, then check that memory was cleared.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = B + 32'd4; cfg_wait = 4'd5;
        @(posedge clk); #1 penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midreset_pready",  32'(pready),  32'h0);
        check("midreset_pslverr", 32'(pslverr), 32'h0);
        check("midreset_prdata",  prdata,       32'h0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, B + 32'd4, 32'h0,         4'h0, 4'd0, 32'h0,         1'b0, -1);
        xfer(1'b1, B + 32'd4, 32'h0BAD_CAFE, 4'hF, 4'd2, 32'h0,         1'b0, -1);
        xfer(1'b0, B + 32'd4, 32'h0,         4'h0, 4'd1, 32'h0BAD_CAFE, 1'b0, -1);

`ifdef APB_SLV_PSTRB_EN
        // Byte-strobed merge, then a read carrying strobes.
        xfer(1'b1, B + 32'd12, 32'h1122_3344, 4'hF,    4'd0, 32'h0,         1'b0, -1);
        xfer(1'b1, B + 32'd12, 32'hAABB_CCDD, 4'b0101, 4'd1, 32'h0,         1'b0, -1);
        xfer(1'b0, B + 32'd12, 32'h0,         4'h0,    4'd0, 32'h11BB_33DD, 1'b0, -1);
        xfer(1'b0, B + 32'd12, 32'h0,         4'h2,    4'd0, 32'h0,         1'b1, -1);
`endif

        // Write aborted at its 2nd wait edge must leave memory untouched.
        xfer(1'b1, B + 32'd16, 32'h0000_0055, 4'hF, 4'd0, 32'h0,         1'b0, -1);
        xfer(1'b1, B + 32'd16, 32'h0000_0077, 4'hF, 4'd4, 32'h0,         1'b0, 1);
        xfer(1'b0, B + 32'd16, 32'h0,         4'h0, 4'd0, 32'h0000_0055, 1'b0, -1);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
